// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
//   Takes a PC from the PC generator. A word-aligned PC is sent to instruction
//   memory, and the response is registered for ID. A misaligned PC is not sent
//   to memory; it produces a faulting NOP directly.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   pc_i            PC from the PC generator
//   flush_i         redirect from ID/EX; kills in-flight fetch work
//   stall_i         ID cannot accept the output this cycle
//   fetch_stall_o   hold request to the PC generator (0 = pc_i consumed)
//   imem_req_*      request handshake (valid/addr out, ready in)
//   imem_rsp_*      response (valid/data/err in, no back-pressure)
//   if_*_o          registered output to ID (valid/inst/pc/fault)
module ifu_fetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        fetch_stall_o,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [63:0] if_pc_o,
  output logic        if_fault_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        drop_q, drop_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] pc_q, pc_d;
  logic        flt_q, flt_d;

  logic        load;
  logic        wr;
  logic [31:0] wr_inst;
  logic [63:0] wr_pc;
  logic        wr_flt;

  // A load needs a free output slot, so the later response write can never
  // overrun an entry that ID has not yet taken. Gating with rst keeps the
  // PC generator held while reset is asserted.
  assign load = rst && (state_q == S_IDLE) && (!vld_q || !stall_i) && !flush_i;

  assign fetch_stall_o  = !load;
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = req_pc_q;

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    req_pc_d = req_pc_q;
    wr       = 1'b0;
    wr_inst  = imem_rsp_data;
    wr_pc    = req_pc_q;
    wr_flt   = imem_rsp_err;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          req_pc_d = pc_i;
          if (pc_i[1:0] == 2'b00) begin
            state_d = S_REQ;
          end else begin
            wr      = 1'b1;
            wr_inst = NOP_INST;
            wr_pc   = pc_i;
            wr_flt  = 1'b1;
          end
        end
      end
      S_REQ: begin
        // The request cannot be withdrawn once offered, so a flush here is
        // remembered and the response is dropped later.
        if (imem_req_ready) begin
          state_d = (drop_q || flush_i) ? S_DROP : S_WAIT;
          drop_d  = 1'b0;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_IDLE;
          wr      = !flush_i;
        end else if (flush_i) begin
          state_d = S_DROP;
        end
      end
      default: begin // S_DROP
        if (imem_rsp_valid) state_d = S_IDLE;
      end
    endcase
  end

  // The payload is left untouched when valid clears, so it holds while stalled.
  always_comb begin
    vld_d  = vld_q;
    inst_d = inst_q;
    pc_d   = pc_q;
    flt_d  = flt_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (wr) begin
      vld_d  = 1'b1;
      inst_d = wr_inst;
      pc_d   = wr_pc;
      flt_d  = wr_flt;
    end else if (vld_q && !stall_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      drop_q   <= 1'b0;
      req_pc_q <= 64'h0;
      vld_q    <= 1'b0;
      inst_q   <= 32'h0;
      pc_q     <= 64'h0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      req_pc_q <= req_pc_d;
      vld_q    <= vld_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      flt_q    <= flt_d;
    end
  end

  assign if_valid_o = vld_q;
  assign if_inst_o  = inst_q;
  assign if_pc_o    = pc_q;
  assign if_fault_o = flt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: per-cycle vector table for ifu_fetch plus hand-written
// sequences for zero-wait latency and a mid-cycle asynchronous reset.
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_i = 64'h0;
  logic        flush_i = 1'b0, stall_i = 1'b0;
  logic        fetch_stall_o;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [63:0] if_pc_o;
  logic        if_fault_o;

  ifu_fetch dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .stall_i(stall_i),
    .fetch_stall_o(fetch_stall_o), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err), .if_valid_o(if_valid_o), .if_inst_o(if_inst_o),
    .if_pc_o(if_pc_o), .if_fault_o(if_fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic        fl, st, rdy, rv;
    logic [31:0] rd;
    logic        re;
    logic        e_fs, e_rqv;
    logic [63:0] e_addr;
    logic        e_v;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic [63:0] pc, input logic fl, st, rdy, rv,
                     input logic [31:0] rd, input logic re, input logic fs, rqv,
                     input logic [63:0] addr, input logic v, input logic [31:0] inst,
                     input logic [63:0] ipc, input logic flt);
    vec_t t;
    t.rst = r; t.pc = pc; t.fl = fl; t.st = st; t.rdy = rdy; t.rv = rv;
    t.rd = rd; t.re = re; t.e_fs = fs; t.e_rqv = rqv; t.e_addr = addr;
    t.e_v = v; t.e_inst = inst; t.e_pc = ipc; t.e_flt = flt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [163:0] act, input logic [163:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [163:0] act, exp;
    int n;
    // rst pc fl st rdy rv data err | fstall rqv addr | v inst pc fault
    add(0,'h80000000,0,0,1,0,0,0,          1,0,0,          0,0,0,0);
    add(1,'h80000000,0,0,1,0,0,0,          0,0,0,          0,0,0,0);           // first load
    add(1,'h80000004,0,0,1,0,0,0,          1,1,'h80000000, 0,0,0,0);           // REQ handshake
    add(1,'h80000004,0,0,1,1,'h93,0,       1,0,0,          0,0,0,0);           // response
    add(1,'h80000004,0,1,1,0,0,0,          1,0,0,          1,'h93,'h80000000,0);
    add(1,'h80000004,0,0,0,0,0,0,          0,0,0,          1,'h93,'h80000000,0);
    for (int i = 0; i < 4; i++)                                                // ready low x4
      add(1,'h80000008,0,0,0,0,0,0,        1,1,'h80000004, 0,'h93,'h80000000,0);
    add(1,'h80000008,0,0,1,0,0,0,          1,1,'h80000004, 0,'h93,'h80000000,0);
    add(1,'h80000100,1,0,1,0,0,0,          1,0,0,          0,'h93,'h80000000,0); // flush in WAIT
    add(1,'h80000100,0,0,1,0,0,0,          1,0,0,          0,'h93,'h80000000,0);
    add(1,'h80000100,0,0,1,1,'hDEADBEEF,0, 1,0,0,          0,'h93,'h80000000,0); // dropped rsp
    add(1,'h80000100,0,0,1,0,0,0,          0,0,0,          0,'h93,'h80000000,0); // redirected load
    add(1,'h80000104,0,0,1,0,0,0,          1,1,'h80000100, 0,'h93,'h80000000,0);
    add(1,'h80000104,0,0,1,1,0,1,          1,0,0,          0,'h93,'h80000000,0); // err rsp
    for (int i = 0; i < 3; i++)                                                // stalled hold
      add(1,'h80000002,0,1,1,0,0,0,        1,0,0,          1,0,'h80000100,1);
    add(1,'h80000002,0,0,1,0,0,0,          0,0,0,          1,0,'h80000100,1);  // misaligned load
    add(1,'h80000008,0,1,1,0,0,0,          1,0,0,          1,'h13,'h80000002,1);
    add(1,'h80000008,0,0,1,0,0,0,          0,0,0,          1,'h13,'h80000002,1);
    add(1,'h8000000c,1,0,0,0,0,0,          1,1,'h80000008, 0,'h13,'h80000002,1); // flush in REQ
    add(1,'h80000200,0,0,1,0,0,0,          1,1,'h80000008, 0,'h13,'h80000002,1);
    add(1,'h80000200,0,0,1,1,'h1234,0,     1,0,0,          0,'h13,'h80000002,1); // DROP rsp
    add(1,'h80000200,0,0,1,0,0,0,          0,0,0,          0,'h13,'h80000002,1);
    add(1,'h80000204,0,0,1,0,0,0,          1,1,'h80000200, 0,'h13,'h80000002,1);
    add(1,'h80000300,1,0,1,1,'h9999,0,     1,0,0,          0,'h13,'h80000002,1); // rsp+flush
    add(1,'h80000300,0,0,1,1,'h5555,0,     0,0,0,          0,'h13,'h80000002,1); // rsp in IDLE
    add(1,'h80000304,0,0,0,1,'h6666,0,     1,1,'h80000300, 0,'h13,'h80000002,1); // rsp in REQ
    add(1,'h80000304,0,0,1,0,0,0,          1,1,'h80000300, 0,'h13,'h80000002,1);
    add(1,'h80000304,0,0,1,1,'h77770003,0, 1,0,0,          0,'h13,'h80000002,1);
    add(1,'h80000400,0,0,1,0,0,0,          0,0,0,          1,'h77770003,'h80000300,0);
    add(1,'h80000404,0,0,1,0,0,0,          1,1,'h80000400, 0,'h77770003,'h80000300,0);
    add(0,'h80000500,0,0,1,0,0,0,          1,0,0,          0,0,0,0);           // reset in WAIT
    add(0,'h80000500,0,0,1,1,'habcd,0,     1,0,0,          0,0,0,0);
    add(1,'h80000500,0,0,1,1,'habcd,0,     0,0,0,          0,0,0,0);           // stale rsp ignored
    add(1,'h80000504,0,0,0,1,'hffff,0,     1,1,'h80000500, 0,0,0,0);
    add(1,'h80000504,0,0,1,0,0,0,          1,1,'h80000500, 0,0,0,0);
    add(1,'h80000504,0,0,1,1,'h11112223,0, 1,0,0,          0,0,0,0);
    add(1,'h80000600,0,1,1,0,0,0,          1,0,0,          1,'h11112223,'h80000500,0);

    foreach (vecs[i]) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      rst = vecs[i].rst; pc_i = vecs[i].pc; flush_i = vecs[i].fl; stall_i = vecs[i].st;
      imem_req_ready = vecs[i].rdy; imem_rsp_valid = vecs[i].rv;
      imem_rsp_data = vecs[i].rd; imem_rsp_err = vecs[i].re;
      @(negedge clk);
      act = {fetch_stall_o, imem_req_valid, imem_req_valid ? imem_req_addr : 64'h0,
             if_valid_o, if_inst_o, if_pc_o, if_fault_o};
      exp = {vecs[i].e_fs, vecs[i].e_rqv, vecs[i].e_rqv ? vecs[i].e_addr : 64'h0,
             vecs[i].e_v, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_flt};
      check($sformatf("row%0d", i), act, exp);
    end

    // Zero-wait memory: output valid three edges after the load cycle.
    @(posedge clk); #1;
    stall_i = 1'b0; pc_i = 64'h80000600; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0600; imem_rsp_err = 1'b0;
    @(negedge clk);
    check("lat_load", {163'h0, fetch_stall_o}, 164'h0);
    n = 0;
    for (int k = 1; k <= 8 && n == 0; k++) begin
      @(posedge clk); #1;
      stall_i = 1'b1;
      @(negedge clk);
      if (if_valid_o) n = k;
    end
    check("lat_cycles", 164'(n), 164'd3);
    check("lat_data", {68'h0, if_inst_o, if_pc_o}, {68'h0, 32'h0000_0600, 64'h80000600});

    // Reset dropped between edges clears outputs with no clock edge.
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst", {160'h0, if_valid_o, if_fault_o, imem_req_valid, fetch_stall_o},
          {160'h0, 4'b0001});
    check("async_rst_data", {68'h0, if_inst_o, if_pc_o}, 164'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
